// File: rtl/rojobot_update_queue.sv
// rtl/rojobot_update_queue.sv - rojobot snapshot FIFO with update interrupt and overrun counter
module rojobot_update_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       upd_sysregs,
  input  logic [DATA_W-1:0]          bot_info,
  input  logic                       pop,
  input  logic                       ack,
  output logic                       irq,
  output logic [DATA_W-1:0]          head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic [CNT_W-1:0]           overrun_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic             upd_q, upd_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             irq_q, irq_d;
  logic [CNT_W-1:0] ovr_q, ovr_d;

  logic push, pop_acc, push_acc, drop;

  // Edge detect, acceptance decisions and next-state for pointers, count, irq and overrun
  always_comb begin
    push     = upd_sysregs & ~upd_q;
    pop_acc  = pop & (count_q != '0);
    // A pop in the same cycle frees the slot, so a full queue can still take the push
    push_acc = push & ((count_q != CW'(DEPTH)) | pop_acc);
    drop     = push & ~push_acc;

    upd_d    = upd_sysregs;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + CW'(push_acc) - CW'(pop_acc);
    irq_d    = irq_q;
    ovr_d    = ovr_q;

    if (pop_acc)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);

    // A new snapshot outranks a coincident acknowledge
    if (push_acc)  irq_d = 1'b1;
    else if (ack)  irq_d = 1'b0;

    if (drop && (ovr_q != '1)) ovr_d = ovr_q + CNT_W'(1);
  end

  // Control state register; upd_q resets high so a held strobe is not seen as an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      upd_q    <= 1'b1;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      irq_q    <= 1'b0;
      ovr_q    <= '0;
    end else begin
      upd_q    <= upd_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      irq_q    <= irq_d;
      ovr_q    <= ovr_d;
    end
  end

  // Snapshot storage; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (!reset && push_acc) mem[wr_ptr_q] <= bot_info;
  end

  // Outputs are decoded from registered state only
  always_comb begin
    empty       = (count_q == '0);
    full        = (count_q == CW'(DEPTH));
    count       = count_q;
    irq         = irq_q;
    overrun_cnt = ovr_q;
    head_data   = empty ? '0 : mem[rd_ptr_q];
  end

endmodule

// File: tb/tb_rojobot_update_queue.sv
// tb/tb_rojobot_update_queue.sv - randomized self-checking bench with queue-based reference model
module tb_rojobot_update_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              reset, upd_sysregs, pop, ack;
  logic [DATA_W-1:0] bot_info;
  logic              irq, empty, full;
  logic [DATA_W-1:0] head_data;
  logic [2:0]        count;
  logic [CNT_W-1:0]  overrun_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] mq [$];
  bit                m_irq;
  int                m_ovr;
  bit                m_prev;

  rojobot_update_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .upd_sysregs(upd_sysregs), .bot_info(bot_info),
    .pop(pop), .ack(ack), .irq(irq), .head_data(head_data), .count(count),
    .empty(empty), .full(full), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour: apply one clock edge to the abstract queue
  task automatic model_edge(input bit r, input bit u, input logic [31:0] d, input bit p, input bit a);
    bit push, pop_ok, acc;
    if (r) begin
      mq.delete(); m_irq = 0; m_ovr = 0; m_prev = 1;
      return;
    end
    push   = u && !m_prev;
    pop_ok = p && (mq.size() > 0);
    acc    = push && ((mq.size() < DEPTH) || pop_ok);
    if (pop_ok) void'(mq.pop_front());
    if (acc) mq.push_back(d);
    if (push && !acc && m_ovr < 255) m_ovr++;
    if (acc) m_irq = 1; else if (a) m_irq = 0;
    m_prev = u;
  endtask

  task automatic check_all();
    check("count", 32'(count), 32'(mq.size()));
    check("empty", 32'(empty), 32'(mq.size() == 0));
    check("full", 32'(full), 32'(mq.size() == DEPTH));
    check("head", head_data, (mq.size() > 0) ? mq[0] : 32'h0);
    check("irq", 32'(irq), 32'(m_irq));
    check("ovr", 32'(overrun_cnt), 32'(m_ovr));
  endtask

  task automatic cyc(input bit r, input bit u, input logic [31:0] d, input bit p, input bit a);
    reset = r; upd_sysregs = u; bot_info = d; pop = p; ack = a;
    @(posedge clk);
    model_edge(r, u, d, p, a);
    #1;
    check_all();
  endtask

  task automatic pulse(input logic [31:0] d, input bit p, input bit a);
    cyc(0, 1, d, p, a);
    cyc(0, 0, 32'h0, 0, 0);
  endtask

  initial begin
    reset = 1; upd_sysregs = 1; bot_info = '0; pop = 0; ack = 0;
    m_irq = 0; m_ovr = 0; m_prev = 1;

    // Held-high strobe through reset produces no edge
    cyc(1, 1, 32'h0, 0, 0);
    cyc(1, 1, 32'h0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 32'hdead_0000 + 32'(i), 0, 0);
    check("held_count", 32'(count), 32'd0);
    check("held_irq", 32'(irq), 32'd0);
    cyc(0, 0, 32'h0, 0, 0);

    // Single snapshot, ack, pop
    cyc(0, 1, 32'h1020_0304, 0, 0);
    check("single_head", head_data, 32'h1020_0304);
    check("single_irq", 32'(irq), 32'd1);
    cyc(0, 0, 32'h0, 0, 1);
    check("ack_irq", 32'(irq), 32'd0);
    check("ack_count", 32'(count), 32'd1);
    cyc(0, 0, 32'h0, 1, 0);
    check("pop_empty", 32'(empty), 32'd1);
    check("pop_head", head_data, 32'h0);

    // Overflow by one, then ordered drain
    for (int k = 1; k <= 5; k++) pulse(32'(k), 0, 0);
    check("five_full", 32'(full), 32'd1);
    check("five_ovr", 32'(overrun_cnt), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      check("drain_head", head_data, 32'(k));
      cyc(0, 0, 32'h0, 1, 0);
    end
    check("drain_empty", 32'(empty), 32'd1);

    // Full queue: push and pop together
    for (int k = 1; k <= 4; k++) pulse(32'h100 + 32'(k), 0, 0);
    cyc(0, 1, 32'd9, 1, 0);
    check("fullpp_count", 32'(count), 32'd4);
    check("fullpp_ovr", 32'(overrun_cnt), 32'd1);
    cyc(0, 0, 32'h0, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 32'h0, 1, 0);
    check("fullpp_tail", head_data, 32'd9);
    cyc(0, 0, 32'h0, 1, 0);

    // Empty queue: push and pop together
    cyc(0, 1, 32'd7, 1, 0);
    check("emptypp_count", 32'(count), 32'd1);
    check("emptypp_head", head_data, 32'd7);
    cyc(0, 0, 32'h0, 0, 1);

    // Push wins over coincident ack
    cyc(0, 1, 32'h55, 0, 0);
    cyc(0, 0, 32'h0, 0, 0);
    cyc(0, 1, 32'h66, 0, 1);
    check("pushack_irq", 32'(irq), 32'd1);
    cyc(0, 0, 32'h0, 0, 0);

    // Saturating overrun counter
    for (int i = 0; i < 300; i++) pulse(32'(i), 0, 0);
    check("ovr_sat", 32'(overrun_cnt), 32'hff);

    // Mid-stream reset
    cyc(1, 0, 32'h0, 0, 0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_ovr", 32'(overrun_cnt), 32'd0);
    check("rst_head", head_data, 32'h0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1), $urandom(),
          ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
